// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch
// port and the data port of a processor core.
// Data requests have priority, but the instruction port wins after STARVE_LIMIT
// back-to-back data grants made while it was waiting.
// Ports:
//   Clock, Reset (async, active-low)
//   Inst*  : instruction requester (read only); InstWaitreq stalls the fetch
//   Data*  : data requester (read/write); DataWaitreq stalls the memory stage
//   Mem*   : single-port memory command/response interface
module mem_port_arbiter #(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] InstAddr,
  input  logic                 InstRead,
  output logic [WORD_SIZE-1:0] InstRdData,
  output logic                 InstWaitreq,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataWrData,
  input  logic                 DataRead,
  input  logic                 DataWrite,
  output logic [WORD_SIZE-1:0] DataRdData,
  output logic                 DataWaitreq,
  output logic [WORD_SIZE-1:0] MemAddr,
  output logic [WORD_SIZE-1:0] MemWrData,
  output logic                 MemRead,
  output logic                 MemWrite,
  input  logic [WORD_SIZE-1:0] MemRdData,
  input  logic                 MemWaitreq
);

  localparam int unsigned LAT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam int unsigned STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPLETE
  } state_t;

  state_t           state;
  logic             owner_inst;   // 1: instruction port owns the memory, 0: data port
  logic             op_write;
  logic [LAT_W-1:0] lat_cnt;
  logic [STV_W-1:0] starve_cnt;

  logic data_req;
  logic inst_pick;

  assign data_req  = DataRead | DataWrite;
  // Instruction port wins when data is idle or it has waited out the starvation limit
  assign inst_pick = InstRead & (~data_req | (starve_cnt == STV_W'(STARVE_LIMIT)));

  // Back-pressure: each port is released only in its own completion cycle
  assign InstWaitreq = InstRead  & ~((state == S_COMPLETE) &  owner_inst);
  assign DataWaitreq = data_req  & ~((state == S_COMPLETE) & ~owner_inst);

  // Arbitration and transaction sequencing
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      owner_inst <= 1'b0;
      op_write   <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      MemAddr    <= '0;
      MemWrData  <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      InstRdData <= '0;
      DataRdData <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (inst_pick) begin
            owner_inst <= 1'b1;
            op_write   <= 1'b0;
            MemAddr    <= InstAddr;
            MemRead    <= 1'b1;
            MemWrite   <= 1'b0;
            starve_cnt <= '0;
            state      <= S_ISSUE;
          end else if (data_req) begin
            owner_inst <= 1'b0;
            // a simultaneous read and write is performed as a write
            op_write   <= DataWrite;
            MemAddr    <= DataAddr;
            MemWrData  <= DataWrData;
            MemRead    <= ~DataWrite;
            MemWrite   <= DataWrite;
            starve_cnt <= InstRead ? (starve_cnt + STV_W'(1)) : '0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!MemWaitreq) begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            if (op_write) begin
              state <= S_COMPLETE;
            end else begin
              lat_cnt <= LAT_W'(READ_LATENCY);
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            if (owner_inst) InstRdData <= MemRdData;
            else            DataRdData <= MemRdData;
            state <= S_COMPLETE;
          end
        end
        S_COMPLETE: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters).
module tb_mem_port_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] InstAddr, InstRdData;
  logic        InstRead, InstWaitreq;
  logic [15:0] DataAddr, DataWrData, DataRdData;
  logic        DataRead, DataWrite, DataWaitreq;
  logic [15:0] MemAddr, MemWrData, MemRdData;
  logic        MemRead, MemWrite, MemWaitreq;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(.WORD_SIZE(16), .READ_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .InstAddr(InstAddr), .InstRead(InstRead), .InstRdData(InstRdData), .InstWaitreq(InstWaitreq),
    .DataAddr(DataAddr), .DataWrData(DataWrData), .DataRead(DataRead), .DataWrite(DataWrite),
    .DataRdData(DataRdData), .DataWaitreq(DataWaitreq),
    .MemAddr(MemAddr), .MemWrData(MemWrData), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemRdData(MemRdData), .MemWaitreq(MemWaitreq)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance into the next cycle; inputs are driven and outputs sampled 2ns after the edge
  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  int grant [10];
  int exp_grant [10];
  int got_n;

  initial begin
    exp_grant = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    Reset = 1'b0;
    InstAddr = '0; InstRead = 1'b0;
    DataAddr = '0; DataWrData = '0; DataRead = 1'b0; DataWrite = 1'b0;
    MemRdData = '0; MemWaitreq = 1'b0;
    #12;
    chk("rst_memaddr", 32'(MemAddr), 32'h0);
    chk("rst_memrd", 32'(MemRead), 32'h0);
    chk("rst_inst_wait_idle", 32'(InstWaitreq), 32'h0);
    InstRead = 1'b1;
    #1;
    chk("rst_inst_wait_follow", 32'(InstWaitreq), 32'h1);
    InstRead = 1'b0;
    #1;
    Reset = 1'b1;
    tick();

    // Instruction fetch, READ_LATENCY=1
    InstRead = 1'b1; InstAddr = 16'h0040;
    #1;
    chk("if_c0_wait", 32'(InstWaitreq), 32'h1);
    chk("if_c0_memrd", 32'(MemRead), 32'h0);
    tick();
    chk("if_c1_memrd", 32'(MemRead), 32'h1);
    chk("if_c1_addr", 32'(MemAddr), 32'h0040);
    chk("if_c1_wait", 32'(InstWaitreq), 32'h1);
    MemRdData = 16'h1234;
    tick();
    chk("if_c2_memrd", 32'(MemRead), 32'h0);
    chk("if_c2_wait", 32'(InstWaitreq), 32'h1);
    tick();
    chk("if_c3_wait", 32'(InstWaitreq), 32'h0);
    chk("if_c3_data", 32'(InstRdData), 32'h1234);
    InstRead = 1'b0;
    tick();

    // Data write stalled by memory for 3 cycles
    DataWrite = 1'b1; DataAddr = 16'h0100; DataWrData = 16'hBEEF;
    tick();
    for (int c = 1; c <= 4; c++) begin
      MemWaitreq = (c <= 3);
      #1;
      chk($sformatf("wr_c%0d_memwr", c), 32'(MemWrite), 32'h1);
      chk($sformatf("wr_c%0d_wait", c), 32'(DataWaitreq), 32'h1);
      tick();
    end
    chk("wr_addr", 32'(MemAddr), 32'h0100);
    chk("wr_wdata", 32'(MemWrData), 32'hBEEF);
    chk("wr_c5_wait", 32'(DataWaitreq), 32'h0);
    chk("wr_c5_memwr", 32'(MemWrite), 32'h0);
    DataWrite = 1'b0;
    tick();

    // Simultaneous requests: data first, then instruction
    InstRead = 1'b1; InstAddr = 16'h0010;
    DataRead = 1'b1; DataAddr = 16'h0200;
    tick();
    chk("sim_c1_addr", 32'(MemAddr), 32'h0200);
    chk("sim_c1_memrd", 32'(MemRead), 32'h1);
    MemRdData = 16'hAAAA;
    tick();
    tick();
    chk("sim_c3_dwait", 32'(DataWaitreq), 32'h0);
    chk("sim_c3_iwait", 32'(InstWaitreq), 32'h1);
    chk("sim_c3_ddata", 32'(DataRdData), 32'hAAAA);
    DataRead = 1'b0;
    tick();
    chk("sim_c4_memrd", 32'(MemRead), 32'h0);
    tick();
    chk("sim_c5_addr", 32'(MemAddr), 32'h0010);
    chk("sim_c5_memrd", 32'(MemRead), 32'h1);
    MemRdData = 16'h5555;
    tick();
    chk("sim_c6_iwait", 32'(InstWaitreq), 32'h1);
    tick();
    chk("sim_c7_iwait", 32'(InstWaitreq), 32'h0);
    chk("sim_c7_idata", 32'(InstRdData), 32'h5555);
    chk("sim_c7_dhold", 32'(DataRdData), 32'hAAAA);
    InstRead = 1'b0;
    tick();

    // Starvation: both requests held, expect D,D,D,D,I,D,D,D,D,I
    for (int i = 0; i < 10; i++) grant[i] = 9;
    got_n = 0;
    InstRead = 1'b1; InstAddr = 16'h0020;
    DataRead = 1'b1; DataAddr = 16'h0220;
    for (int cyc = 0; cyc < 300 && got_n < 10; cyc++) begin
      tick();
      if (!DataWaitreq) begin
        grant[got_n] = 0;
        got_n = got_n + 1;
      end else if (!InstWaitreq) begin
        grant[got_n] = 1;
        got_n = got_n + 1;
      end
    end
    InstRead = 1'b0; DataRead = 1'b0;
    chk("starve_count", 32'(got_n), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve_grant%0d", i), 32'(grant[i]), 32'(exp_grant[i]));
    tick();

    // Reset asserted during WAIT of an instruction read
    InstRead = 1'b1; InstAddr = 16'h0050;
    tick();
    chk("rstw_c1_memrd", 32'(MemRead), 32'h1);
    MemRdData = 16'h9999;
    tick();
    Reset = 1'b0;
    #1;
    chk("rstw_memrd", 32'(MemRead), 32'h0);
    chk("rstw_memwr", 32'(MemWrite), 32'h0);
    chk("rstw_idata", 32'(InstRdData), 32'h0);
    chk("rstw_ddata", 32'(DataRdData), 32'h0);
    chk("rstw_addr", 32'(MemAddr), 32'h0);
    chk("rstw_iwait", 32'(InstWaitreq), 32'h1);
    InstRead = 1'b0;
    #1;
    Reset = 1'b1;
    tick();
    chk("rstw_idata_after", 32'(InstRdData), 32'h0);
    DataRead = 1'b1; DataAddr = 16'h0300;
    tick();
    chk("rstw_new_addr", 32'(MemAddr), 32'h0300);
    chk("rstw_new_memrd", 32'(MemRead), 32'h1);
    MemRdData = 16'h0C0D;
    tick();
    chk("rstw_new_c2_wait", 32'(DataWaitreq), 32'h1);
    tick();
    chk("rstw_new_c3_wait", 32'(DataWaitreq), 32'h0);
    chk("rstw_new_data", 32'(DataRdData), 32'h0C0D);
    DataRead = 1'b0;
    tick();

    // Read and write together behave as a write
    DataRead = 1'b1; DataWrite = 1'b1; DataAddr = 16'h0400; DataWrData = 16'h7777;
    #1;
    chk("rw_c0_memrd", 32'(MemRead), 32'h0);
    chk("rw_c0_memwr", 32'(MemWrite), 32'h0);
    tick();
    chk("rw_c1_memwr", 32'(MemWrite), 32'h1);
    chk("rw_c1_memrd", 32'(MemRead), 32'h0);
    chk("rw_c1_wdata", 32'(MemWrData), 32'h7777);
    chk("rw_c1_wait", 32'(DataWaitreq), 32'h1);
    tick();
    chk("rw_c2_wait", 32'(DataWaitreq), 32'h0);
    chk("rw_c2_memwr", 32'(MemWrite), 32'h0);
    chk("rw_c2_memrd", 32'(MemRead), 32'h0);
    DataRead = 1'b0; DataWrite = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
